// File: rtl/halfband_decimator_pkg.sv
// Shared constants and types for the halfband decimator.
// HB_H1 / HB_H3 are the same 0s18 coefficients used by the transmit interpolator.
package halfband_decimator_pkg;

    // Sample, coefficient and arithmetic widths
    localparam int SAMPLE_W     = 18;  // 1s17
    localparam int COEF_W       = 18;  // 0s18 value, held as signed so H1 can be negative
    localparam int PRE_W        = 19;  // 2s17 pre-add, exact
    localparam int PROD_W       = 37;  // 2s35 product
    localparam int ACC_W        = 38;  // 3s35 accumulator
    localparam int TAPS         = 7;
    localparam int CENTRE_SHIFT = 17;  // aligns d3 (2^-17) with 0.5 at 2^-35 weight
    localparam int OUT_LSB      = 18;  // acc[35:18] is the 1s17 output
    localparam int OUT_MSB      = OUT_LSB + SAMPLE_W - 1;

    // Halfband coefficients (value / 2^18); centre tap 0.5 is a shift, not a constant
    localparam logic signed [COEF_W-1:0] HB_H1 = -18'sd9220;
    localparam logic signed [COEF_W-1:0] HB_H3 = 18'sd74920;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Sign-extend a 2s35 product into the 3s35 accumulator
    function automatic acc_t ext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/halfband_dec_sat.sv
// 38->18 output stage: floor truncation of the 3s35 accumulator to 1s17.
// Clamping on overflow is built only when HALFBAND_DEC_SAT_EN is defined;
// otherwise the result simply wraps.
module halfband_dec_sat
    import halfband_decimator_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] result
);

`ifdef HALFBAND_DEC_SAT_EN
    logic in_range;
    logic unused_acc;

    // Result fits 1s17 only when the three top accumulator bits agree
    assign in_range   = (acc[ACC_W-1:OUT_MSB] == '0) || (acc[ACC_W-1:OUT_MSB] == '1);
    assign unused_acc = ^acc[OUT_LSB-1:0];

    // Clamp toward the accumulator sign when out of range
    always_comb begin
        result = acc[OUT_MSB:OUT_LSB];
        if (!in_range) begin
            result = acc[ACC_W-1] ? SAMPLE_MIN : SAMPLE_MAX;
        end
    end
`else
    logic unused_acc;

    // Plain truncation; overflow wraps
    assign result     = acc[OUT_MSB:OUT_LSB];
    assign unused_acc = ^{acc[ACC_W-1:OUT_MSB+1], acc[OUT_LSB-1:0]};
`endif

endmodule

// File: rtl/halfband_decimator.sv
// Halfband 2:1 decimating FIR, 7 taps with zero odd taps, 1s17 in and out.
// The MAC only matters on output instants: y loads one clk after the sample
// edge that completes each pair. Optional output clamping: HALFBAND_DEC_SAT_EN.
module halfband_decimator
    import halfband_decimator_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_en,
    input  logic                       phase_sync,
    input  logic signed [SAMPLE_W-1:0] x_in,
    output logic signed [SAMPLE_W-1:0] y,
    output logic                       y_valid
);

    sample_t d [TAPS];
    logic    ph;
    logic    go;

    logic signed [PRE_W-1:0]    pre_outer;
    logic signed [PRE_W-1:0]    pre_inner;
    logic signed [PROD_W-1:0]   prod_outer;
    logic signed [PROD_W-1:0]   prod_inner;
    acc_t                       centre;
    acc_t                       acc;
    logic signed [SAMPLE_W-1:0] y_next;

    // Delay line, d[0] newest, advances only on accepted samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                d[k] <= '0;
            end
        end else if (in_en) begin
            d[0] <= x_in;
            for (int k = 1; k < TAPS; k++) begin
                d[k] <= d[k-1];
            end
        end
    end

    // Decimation phase and compute request; phase_sync realigns and drops this output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= 1'b0;
            go <= 1'b0;
        end else begin
            go <= in_en & ph & ~phase_sync;
            if (phase_sync) begin
                ph <= 1'b0;
            end else if (in_en) begin
                ph <= ~ph;
            end
        end
    end

    // Symmetric pre-adds in 2s17; one bit of growth keeps them exact
    assign pre_outer = {d[0][SAMPLE_W-1], d[0]} + {d[6][SAMPLE_W-1], d[6]};
    assign pre_inner = {d[2][SAMPLE_W-1], d[2]} + {d[4][SAMPLE_W-1], d[4]};

    // Full-precision 2s35 products, operands sign-extended to product width
    assign prod_outer = $signed({{(PROD_W-PRE_W){pre_outer[PRE_W-1]}}, pre_outer})
                      * $signed({{(PROD_W-COEF_W){HB_H1[COEF_W-1]}}, HB_H1});
    assign prod_inner = $signed({{(PROD_W-PRE_W){pre_inner[PRE_W-1]}}, pre_inner})
                      * $signed({{(PROD_W-COEF_W){HB_H3[COEF_W-1]}}, HB_H3});

    // Centre tap 0.5: d3 placed at 2^-35 weight is d3 * 2^17
    assign centre = {{(ACC_W-SAMPLE_W-CENTRE_SHIFT){d[3][SAMPLE_W-1]}}, d[3],
                     {CENTRE_SHIFT{1'b0}}};

    assign acc = ext_prod(prod_outer) + ext_prod(prod_inner) + centre;

    halfband_dec_sat u_sat (
        .acc    (acc),
        .result (y_next)
    );

    // Output register; y samples the delay line as it stood before this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= go;
            if (go) begin
                y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_halfband_decimator.sv
// Self-checking bench for halfband_decimator: a behavioural model pushes the
// expected y into a queue when an output is due; the monitor pops on y_valid.
module tb_halfband_decimator;

    localparam int C_H1 = -9220;
    localparam int C_H3 = 74920;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_en;
    logic               phase_sync;
    logic signed [17:0] x_in;
    logic signed [17:0] y;
    logic               y_valid;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int got_q[$];

    int   md [7];
    logic m_ph;
    logic m_go;
    logic m_valid;

    always #5 clk = ~clk;

    halfband_decimator dut (
        .clk        (clk),
        .reset      (reset),
        .in_en      (in_en),
        .phase_sync (phase_sync),
        .x_in       (x_in),
        .y          (y),
        .y_valid    (y_valid)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference filter on the model delay line, straight from the equation
    function automatic int model_y();
        longint       acc;
        longint       s;
        logic [17:0]  t;
        acc = longint'(C_H1) * longint'(md[0] + md[6])
            + longint'(C_H3) * longint'(md[2] + md[4])
            + longint'(md[3]) * 64'sd131072;
`ifdef HALFBAND_DEC_SAT_EN
        if (acc >= 64'sd34359738368) return 131071;
        if (acc < -64'sd34359738368) return -131072;
`endif
        s = acc >>> 18;
        t = s[17:0];
        return int'($signed(t));
    endfunction

    // Cycle model of delay line, phase and output timing
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 7; k++) md[k] <= 0;
            m_ph    <= 1'b0;
            m_go    <= 1'b0;
            m_valid <= 1'b0;
            exp_q.delete();
        end else begin
            if (m_go) exp_q.push_back(model_y());
            m_valid <= m_go;
            m_go    <= in_en & m_ph & ~phase_sync;
            if (in_en) begin
                md[0] <= int'(x_in);
                for (int k = 1; k < 7; k++) md[k] <= md[k-1];
            end
            if (phase_sync) m_ph <= 1'b0;
            else if (in_en) m_ph <= ~m_ph;
        end
    end

    // Monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        int e;
        if (!reset) begin
            check("y_valid", int'(y_valid), int'(m_valid));
            if (y_valid) begin
                if (exp_q.size() == 0) begin
                    check("y_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("y", int'(y), e);
                end
                got_q.push_back(int'(y));
            end
        end
    end

    task automatic step(input logic en, input logic sync, input int x);
        in_en      = en;
        phase_sync = sync;
        x_in       = x[17:0];
        @(posedge clk);
        #1;
        in_en      = 1'b0;
        phase_sync = 1'b0;
        x_in       = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int exp []);
        check({tag, "_count"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check(tag, (i < got_q.size()) ? got_q[i] : 999999, exp[i]);
        end
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(262143, 0)) - 131072;
    endfunction

    initial begin
        int imp1 [];
        int imp2 [];
        int sat_exp;

        reset      = 1'b1;
        in_en      = 1'b0;
        phase_sync = 1'b0;
        x_in       = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_y", int'(y), 0);
        check("reset_valid", int'(y_valid), 0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Impulse as the first sample: only the centre tap contributes
        got_q.delete();
        step(1'b1, 1'b0, 65536);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 0);
        idle(3);
        imp1 = '{0, 32768, 0, 0};
        check_seq("imp1", imp1);

        // Impulse as the second sample walks the even taps
        do_reset();
        got_q.delete();
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 65536);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0);
        idle(3);
        imp2 = '{-2305, 18730, 18730, -2305, 0};
        check_seq("imp2", imp2);

        // Full-scale DC input overflows the accumulator range
        do_reset();
        got_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 131071);
        idle(3);
`ifdef HALFBAND_DEC_SAT_EN
        sat_exp = 131071;
`else
        sat_exp = -130910;
`endif
        check("dc_count", got_q.size(), 4);
        check("dc_steady", (got_q.size() == 4) ? got_q[3] : 999999, sat_exp);

        // Back-to-back random samples, then one sample every third cycle
        do_reset();
        got_q.delete();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, rnd_sample());
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, rnd_sample());
            idle(2);
        end
        idle(2);
        check("stream_count", got_q.size(), 20);

        // phase_sync with in_en on an output edge: dropped, restart needs two samples
        got_q.delete();
        step(1'b1, 1'b0, rnd_sample());
        step(1'b1, 1'b1, rnd_sample());
        idle(2);
        check("sync_suppressed", got_q.size(), 0);
        step(1'b1, 1'b0, rnd_sample());
        idle(2);
        check("sync_one_sample", got_q.size(), 0);
        step(1'b1, 1'b0, rnd_sample());
        idle(2);
        check("sync_resumed", got_q.size(), 1);

        // Reset landing between E0 and E1 cancels the pending output
        got_q.delete();
        step(1'b1, 1'b0, rnd_sample());
        step(1'b1, 1'b0, rnd_sample());
        #2 reset = 1'b1;
        #4 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_y", int'(y), 0);
        check("rst_mid_valid", int'(y_valid), 0);
        idle(2);
        check("rst_mid_none", got_q.size(), 0);
        step(1'b1, 1'b0, rnd_sample());
        idle(2);
        check("rst_one_sample", got_q.size(), 0);
        step(1'b1, 1'b0, rnd_sample());
        idle(2);
        check("rst_resumed", got_q.size(), 1);

        idle(3);
        check("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
